// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port word memory.
// Each access takes one cycle each in IDLE, ACCESS and RESP. Misaligned and out-of-range accesses fault without enabling memory.
module mem_arbiter #(
    parameter int MEM_SIZE   = 64000,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(MEM_SIZE - 4);

    state_t      state_reg, state_next;
    logic        if_gnt_reg, if_gnt_next;
    logic        if_rvalid_reg, if_rvalid_next;
    logic        if_fault_reg, if_fault_next;
    logic        d_gnt_reg, d_gnt_next;
    logic        d_rvalid_reg, d_rvalid_next;
    logic        d_fault_reg, d_fault_next;
    logic        mem_enable_reg, mem_enable_next;
    logic        mem_write_reg, mem_write_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic [31:0] mem_data_in_reg, mem_data_in_next;
    logic        owner_d_reg, owner_d_next;
    logic        last_d_reg, last_d_next;

    // Index 0 is the fetch port, index 1 the data port.
    logic [31:0] port_addr [2];
    logic [1:0]  port_legal;
    logic        pick_d;

    assign port_addr[0] = if_addr;
    assign port_addr[1] = d_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_legal
            assign port_legal[gi] = (port_addr[gi][1:0] == 2'b00) && (port_addr[gi] <= MAX_ADDR);
        end
    endgenerate

    // Data wins when alone, under fixed priority, or when fetch was granted last.
    assign pick_d = d_req && (!if_req || FIXED_PRIO || !last_d_reg);

    always_comb begin
        state_next       = state_reg;
        if_gnt_next      = 1'b0;
        if_rvalid_next   = 1'b0;
        if_fault_next    = 1'b0;
        d_gnt_next       = 1'b0;
        d_rvalid_next    = 1'b0;
        d_fault_next     = 1'b0;
        mem_enable_next  = 1'b0;
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_data_in_next = mem_data_in_reg;
        owner_d_next     = owner_d_reg;
        last_d_next      = last_d_reg;

        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d_next = pick_d;
                    last_d_next  = pick_d;
                    if (pick_d) begin
                        d_gnt_next = 1'b1;
                        if (port_legal[1]) begin
                            mem_enable_next  = 1'b1;
                            mem_write_next   = d_we;
                            mem_address_next = d_addr;
                            mem_data_in_next = d_wdata;
                            state_next       = ACCESS;
                        end else begin
                            d_rvalid_next = 1'b1;
                            d_fault_next  = 1'b1;
                            state_next    = FAULT;
                        end
                    end else begin
                        if_gnt_next = 1'b1;
                        if (port_legal[0]) begin
                            mem_enable_next  = 1'b1;
                            mem_write_next   = 1'b0;
                            mem_address_next = if_addr;
                            state_next       = ACCESS;
                        end else begin
                            if_rvalid_next = 1'b1;
                            if_fault_next  = 1'b1;
                            state_next     = FAULT;
                        end
                    end
                end
            end
            ACCESS: begin
                if (owner_d_reg) d_rvalid_next  = 1'b1;
                else             if_rvalid_next = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            if_gnt_reg      <= 1'b0;
            if_rvalid_reg   <= 1'b0;
            if_fault_reg    <= 1'b0;
            d_gnt_reg       <= 1'b0;
            d_rvalid_reg    <= 1'b0;
            d_fault_reg     <= 1'b0;
            mem_enable_reg  <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_data_in_reg <= '0;
            owner_d_reg     <= 1'b0;
            last_d_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            if_gnt_reg      <= if_gnt_next;
            if_rvalid_reg   <= if_rvalid_next;
            if_fault_reg    <= if_fault_next;
            d_gnt_reg       <= d_gnt_next;
            d_rvalid_reg    <= d_rvalid_next;
            d_fault_reg     <= d_fault_next;
            mem_enable_reg  <= mem_enable_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_data_in_reg <= mem_data_in_next;
            owner_d_reg     <= owner_d_next;
            last_d_reg      <= last_d_next;
        end
    end

    assign if_gnt      = if_gnt_reg;
    assign if_rvalid   = if_rvalid_reg;
    assign if_fault    = if_fault_reg;
    assign d_gnt       = d_gnt_reg;
    assign d_rvalid    = d_rvalid_reg;
    assign d_fault     = d_fault_reg;
    assign mem_enable  = mem_enable_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_data_in = mem_data_in_reg;

    // The memory's read register is the output register for read data; gate it to the owner in RESP.
    assign if_rdata = (if_rvalid_reg && !if_fault_reg) ? mem_data_out : '0;
    assign d_rdata  = (d_rvalid_reg && !d_fault_reg && !mem_write_reg) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin DUT with a word memory model, plus a fixed-priority
// DUT on the same request inputs for the tie-break check.
module tb_mem_arbiter;

    localparam int MEM_SIZE = 64000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_enable, mem_write;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    logic        p1_if_gnt, p1_if_rvalid, p1_if_fault, p1_d_gnt, p1_d_rvalid, p1_d_fault;
    logic [31:0] p1_if_rdata, p1_d_rdata;
    logic        p1_mem_enable, p1_mem_write;
    logic [31:0] p1_mem_address, p1_mem_data_in;

    logic        pre_en;
    logic [13:0] pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem [16384];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_SIZE(MEM_SIZE), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_fault(if_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.MEM_SIZE(MEM_SIZE), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(p1_if_gnt), .if_rvalid(p1_if_rvalid),
        .if_rdata(p1_if_rdata), .if_fault(p1_if_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(p1_d_gnt),
        .d_rvalid(p1_d_rvalid), .d_rdata(p1_d_rdata), .d_fault(p1_d_fault),
        .mem_enable(p1_mem_enable), .mem_write(p1_mem_write), .mem_address(p1_mem_address),
        .mem_data_in(p1_mem_data_in), .mem_data_out(32'h0)
    );

    // Word memory with registered read, plus a preload port used only while in reset.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_enable) begin
            if (mem_write) mem[mem_address[15:2]] <= mem_data_in;
            else           mem_data_out <= mem[mem_address[15:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {24'h0, if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault,
                              mem_enable, mem_write}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_mem_address"}, mem_address, 32'h0);
        chk({tag, "_mem_data_in"}, mem_data_in, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pre_words [4];
        logic [13:0] pre_slots [4];
        logic [31:0] b2b_data [3];
        pre_words = '{32'hE3A00001, 32'h11111111, 32'h22222222, 32'h33333333};
        pre_slots = '{14'd64, 14'd0, 14'd1, 14'd2};
        b2b_data  = '{32'h11111111, 32'h22222222, 32'h33333333};

        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            pre_en = 1'b1; pre_idx = pre_slots[i]; pre_val = pre_words[i];
            tick();
        end
        pre_en = 1'b0;
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk_all_zero("idle_after_reset");

        // Single fetch of 0x100.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch_gnt", {31'h0, if_gnt}, 32'h1);
        chk("fetch_mem_enable", {31'h0, mem_enable}, 32'h1);
        chk("fetch_mem_write", {31'h0, mem_write}, 32'h0);
        chk("fetch_mem_address", mem_address, 32'h100);
        chk("fetch_no_early_rvalid", {31'h0, if_rvalid}, 32'h0);
        if_req = 1'b0;
        tick();
        chk("fetch_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("fetch_rdata", if_rdata, 32'hE3A00001);
        chk("fetch_fault", {31'h0, if_fault}, 32'h0);
        chk("fetch_mem_enable_off", {31'h0, mem_enable}, 32'h0);
        tick();
        chk("fetch_rvalid_once", {31'h0, if_rvalid}, 32'h0);

        // Store then load at 0x200.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick();
        chk("store_gnt", {31'h0, d_gnt}, 32'h1);
        chk("store_mem_write", {31'h0, mem_write}, 32'h1);
        chk("store_mem_data_in", mem_data_in, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();
        chk("store_ack", {31'h0, d_rvalid}, 32'h1);
        chk("store_rdata", d_rdata, 32'h0);
        chk("store_fault", {31'h0, d_fault}, 32'h0);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick();
        chk("load_gnt", {31'h0, d_gnt}, 32'h1);
        d_req = 1'b0;
        tick();
        chk("load_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("load_rdata", d_rdata, 32'hDEADBEEF);
        chk("load_no_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        tick();

        // Both ports held after reset: round-robin D,F,D,F; fixed priority always D.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk($sformatf("rr_d_gnt_%0d", g), {31'h0, d_gnt}, (g % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr_if_gnt_%0d", g), {31'h0, if_gnt}, (g % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("fp_d_gnt_%0d", g), {31'h0, p1_d_gnt}, 32'h1);
            chk($sformatf("fp_if_gnt_%0d", g), {31'h0, p1_if_gnt}, 32'h0);
            tick();
            chk($sformatf("rr_d_rvalid_%0d", g), {31'h0, d_rvalid}, (g % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr_if_rvalid_%0d", g), {31'h0, if_rvalid}, (g % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("fp_d_rvalid_%0d", g), {31'h0, p1_d_rvalid}, 32'h1);
            tick();
        end

        // Faults: misaligned data (wins the tie) and out-of-range fetch.
        d_addr = 32'h202;
        if_addr = 32'(MEM_SIZE - 2);
        tick();
        chk("dfault_gnt", {31'h0, d_gnt}, 32'h1);
        chk("dfault_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("dfault_fault", {31'h0, d_fault}, 32'h1);
        chk("dfault_rdata", d_rdata, 32'h0);
        chk("dfault_mem_enable", {31'h0, mem_enable}, 32'h0);
        chk("dfault_if_gnt", {31'h0, if_gnt}, 32'h0);
        d_req = 1'b0;
        tick();
        chk("dfault_idle_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("dfault_idle_mem_enable", {31'h0, mem_enable}, 32'h0);
        tick();
        chk("ifault_gnt", {31'h0, if_gnt}, 32'h1);
        chk("ifault_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("ifault_fault", {31'h0, if_fault}, 32'h1);
        chk("ifault_rdata", if_rdata, 32'h0);
        chk("ifault_mem_enable", {31'h0, mem_enable}, 32'h0);
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'(MEM_SIZE);
        tick();
        chk("limit_fault", {31'h0, if_fault}, 32'h1);
        chk("limit_mem_enable", {31'h0, mem_enable}, 32'h0);
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'(MEM_SIZE - 4);
        tick();
        chk("last_word_gnt", {31'h0, if_gnt}, 32'h1);
        chk("last_word_mem_enable", {31'h0, mem_enable}, 32'h1);
        chk("last_word_no_fault", {31'h0, if_fault}, 32'h0);
        if_req = 1'b0;
        tick();
        chk("last_word_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("last_word_fault", {31'h0, if_fault}, 32'h0);
        tick();

        // Reset during ACCESS drops the access.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("abort_mem_enable", {31'h0, mem_enable}, 32'h1);
        reset = 1'b1; if_req = 1'b0;
        tick();
        chk_all_zero("abort_reset");
        reset = 1'b0;
        tick();
        chk("abort_no_rvalid", {31'h0, if_rvalid}, 32'h0);
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("abort_refetch_gnt", {31'h0, if_gnt}, 32'h1);
        if_req = 1'b0;
        tick();
        chk("abort_refetch_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("abort_refetch_rdata", if_rdata, 32'hE3A00001);
        tick();

        // Back-to-back fetches 0x0, 0x4, 0x8.
        if_req = 1'b1; if_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("b2b_gnt_%0d", i), {31'h0, if_gnt}, 32'h1);
            if (i == 2) if_req = 1'b0;
            else        if_addr = 32'(4 * (i + 1));
            tick();
            chk($sformatf("b2b_rvalid_%0d", i), {31'h0, if_rvalid}, 32'h1);
            chk($sformatf("b2b_rdata_%0d", i), if_rdata, b2b_data[i]);
            tick();
            chk($sformatf("b2b_gap_%0d", i), {31'h0, if_rvalid}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
